imem_arbiter: RTL

Single-port arbiter and sequencer in front of the instruction BRAM. It shares the one synchronous-read memory port between the core's fetch stage and a program-loader/debug port. The loader can read and write, and normally wins, but a fairness counter stops it from starving fetch. The block sits between the fetch stage / loader and the BRAM. It tracks each in-flight read so every read response returns to the requester that issued it.

---
 rtl/imem_arbiter.sv | 60 ++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous-read BRAM port between fetch and loader.
// The loader wins by default, but after MAX_LDR_BURST consecutive loader wins a waiting fetch is served.
module imem_arbiter #(
  parameter int ADDR_SIZE     = 7,
  parameter int MAX_LDR_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_req,
  input  logic [31:0]          f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [31:0]          f_rdata,
  input  logic                 l_req,
  input  logic                 l_we,
  input  logic [31:0]          l_addr,
  input  logic [31:0]          l_wdata,
  output logic                 l_gnt,
  output logic                 l_rvalid,
  output logic [31:0]          l_rdata,
  output logic                 l_err,
  output logic                 m_en,
  output logic                 m_we,
  output logic [ADDR_SIZE-2:0] m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata
);
  localparam int SCW = $clog2(MAX_LDR_BURST + 1);
  localparam logic [1:0] OWN_NONE = 2'd0, OWN_F = 2'd1, OWN_L = 2'd2, OWN_ERR = 2'd3;
  logic [SCW-1:0] sc;
  logic [1:0]     owner;
  logic           starve, l_bad;
  logic           f_addr_unused;
  assign f_addr_unused = ^{f_addr[31:ADDR_SIZE+1], f_addr[1:0]};
  always_comb begin
    starve  = f_req && sc == SCW'(MAX_LDR_BURST);
    l_bad   = |l_addr[1:0] || |l_addr[31:ADDR_SIZE+1];
    f_gnt   = rst && f_req && (!l_req || starve);
    l_gnt   = rst && l_req && !starve;
    m_en    = f_gnt || (l_gnt && !l_bad);
    m_we    = l_gnt && !l_bad && l_we;
    m_addr  = l_gnt ? l_addr[ADDR_SIZE:2] : f_addr[ADDR_SIZE:2];
    m_wdata = l_wdata;
  end
  // Errored loader accesses still take a grant slot, so they count toward starvation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sc    <= '0;
      owner <= OWN_NONE;
    end else begin
      sc    <= (!f_req || f_gnt) ? '0 : sc + SCW'(l_gnt);
      owner <= f_gnt ? OWN_F : !l_gnt ? OWN_NONE : l_bad ? OWN_ERR : l_we ? OWN_NONE : OWN_L;
    end
  end
  assign f_rvalid = owner == OWN_F;
  assign l_rvalid = owner == OWN_L;
  assign l_err    = owner == OWN_ERR;
  assign f_rdata  = m_rdata;
  assign l_rdata  = m_rdata;
endmodule
